mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single core memory port between the instruction fetch unit (m0, read-only) and the load/store unit (m1, read/write). The load/store requests come from the execute stage's mem_ren/mem_wen/mem_addr/wmask outputs.
- Arbitrates round-robin, owns one transaction at a time, and sequences it on the slave port.
- Guards every transaction with a response timeout, so a dead slave cannot hang the core.

Parameters:
- TIMEOUT, 256, cycles from the grant edge to forced completion with error; legal range is 4 to 65535.
- CW, 16, width of the timeout counter.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_m0_valid  in  1  IFU read request
- i_m0_addr  in  32  IFU address
- o_m0_ready  out  1  IFU request accepted this cycle
- o_m0_rvalid  out  1  IFU response pulse
- o_m0_rdata  out  32  IFU read data
- o_m0_err  out  1  IFU response error
- i_m1_valid  in  1  LSU request
- i_m1_wen  in  1  1 = write, 0 = read
- i_m1_addr  in  32  LSU address
- i_m1_wdata  in  32  LSU write data
- i_m1_wmask  in  4  LSU byte write mask
- o_m1_ready  out  1  LSU request accepted this cycle
- o_m1_rvalid  out  1  LSU response pulse
- o_m1_rdata  out  32  LSU read data (0 for writes)
- o_m1_err  out  1  LSU response error
- o_s_valid  out  1  slave request valid
- o_s_wen  out  1  slave write enable
- o_s_addr  out  32  slave address
- o_s_wdata  out  32  slave write data
- o_s_wmask  out  4  slave write mask
- i_s_ready  in  1  slave accepted the request
- i_s_rvalid  in  1  slave response valid
- i_s_rdata  in  32  slave read data
- i_s_err  in  1  slave error
- o_busy  out  1  state != IDLE
- o_owner  out  1  current or last owner (0 = m0, 1 = m1)

Behaviour:
- Reset (i_clock, i_reset synchronous, active-high):
  - state=IDLE; counter=0; last_gnt=0, so m1 wins the first tie.
  - All slave request outputs are 0. All rvalid/err/rdata outputs are 0.
  - Reset asserted mid-transaction abandons the transaction: no rvalid pulse is produced. A later i_s_rvalid arriving in IDLE is ignored.
- States: IDLE, REQ, RESP.
- IDLE:
  - Winner: if only one valid, that master wins. If both are valid, the master with id != last_gnt wins.
  - o_mX_ready is combinational: (state==IDLE) & winner==X. It is 1 for exactly one master per grant.
  - At the grant edge: latch addr, wen (forced 0 for m0), wdata, wmask (forced 0 for m0); set owner and last_gnt=X; counter=0; go to REQ.
  - Non-winner: o_mX_ready=0 and it keeps waiting. A master must hold valid and payload until it sees ready.
- REQ:
  - o_s_valid=1 with the latched payload, held stable until the edge where i_s_ready=1.
  - On i_s_ready: go to RESP.
  - If i_s_ready and i_s_rvalid are both 1 in the same cycle, complete directly (see completion).
- RESP:
  - o_s_valid=0.
  - i_s_rvalid=1 completes the transaction.
- Completion (registered, same edge):
  - o_{owner}_rvalid pulses high for exactly 1 cycle.
  - o_{owner}_err=i_s_err.
  - o_{owner}_rdata = i_s_rdata for reads, 0 for writes.
  - rdata/err hold their values until that master's next completion.
  - state returns to IDLE. A new grant is allowed in the same cycle the rvalid pulse is visible.
- Timeout:
  - The counter increments every cycle in REQ and RESP.
  - When counter==TIMEOUT-1 and no completion occurs that cycle: go to IDLE, pulse o_{owner}_rvalid with err=1 and rdata=0, and drop o_s_valid.
  - A completion arriving in the same cycle as the timeout wins; it is a normal response.
- i_s_ready and i_s_rvalid are ignored in IDLE; i_s_rvalid is ignored in REQ unless it arrives together with i_s_ready.
- Minimum latency: grant edge, then REQ accepted, then RESP response, then rvalid, giving 3 cycles from ready to rvalid.
- At most one transaction is outstanding, with no reordering. Never assert both o_m0_ready and o_m1_ready, and never both rvalids, in one cycle.
- o_owner reflects the latched owner from the grant edge onward.

Test Plan:
- Single m0 read at addr 0x80000000; the slave gives ready 1 cycle after valid and rvalid 2 cycles later with rdata 0x00000413. Required: o_m0_ready 1 cycle, o_s_addr=0x80000000, o_s_wen=0, o_m0_rvalid 1-cycle pulse, o_m0_rdata=0x00000413, err=0.
- m1 write with addr 0x80001004, wdata 0xDEADBEEF, wmask 4'b0011. Required: o_s_wen=1 with the payload held stable through 3 stall cycles of i_s_ready=0; o_m1_rvalid pulse; o_m1_rdata=0.
- Both masters valid continuously after reset. Required grant order m1, m0, m1, m0; no cycle has both readys high.
- Slave never asserts rvalid with TIMEOUT=8. Required: o_m0_rvalid pulses with err=1 and rdata=0 exactly 8 cycles after the grant edge; state returns to IDLE, and a late i_s_rvalid in IDLE causes no pulse.
- i_s_ready and i_s_rvalid asserted together with rdata 0x12345678. Required: completion on that edge and o_m1_rdata=0x12345678; the next grant is possible 1 cycle later.
- i_reset raised while in RESP. Required next cycle: o_busy=0 and o_s_valid=0 with no rvalid pulse; after release, m1 wins a tie.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one slave memory port between the instruction fetch unit (m0,
//   read-only) and the load/store unit (m1, read/write). Masters are granted
//   round-robin. Only one transaction is in flight at a time. Every
//   transaction is guarded by a response timeout, so a dead slave completes
//   with an error instead of hanging the core.
//
// Ports
//   i_clock, i_reset   clock; synchronous active-high reset
//   i_m0_*             IFU request (valid, addr)
//   o_m0_*             IFU accept (ready) and response (rvalid, rdata, err)
//   i_m1_*             LSU request (valid, wen, addr, wdata, wmask)
//   o_m1_*             LSU accept (ready) and response (rvalid, rdata, err)
//   o_s_*              slave request (valid, wen, addr, wdata, wmask)
//   i_s_*              slave handshake/response (ready, rvalid, rdata, err)
//   o_busy             a transaction is owned (state != IDLE)
//   o_owner            current or last owner (0 = m0, 1 = m1)
module mem_bus_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int CW      = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_m0_valid,
  input  logic [31:0] i_m0_addr,
  output logic        o_m0_ready,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_err,
  input  logic        i_m1_valid,
  input  logic        i_m1_wen,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [3:0]  i_m1_wmask,
  output logic        o_m1_ready,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_err,
  output logic        o_s_valid,
  output logic        o_s_wen,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_wdata,
  output logic [3:0]  o_s_wmask,
  input  logic        i_s_ready,
  input  logic        i_s_rvalid,
  input  logic [31:0] i_s_rdata,
  input  logic        i_s_err,
  output logic        o_busy,
  output logic        o_owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] counter_q, counter_d;
  logic          last_gnt_q, last_gnt_d;
  logic          owner_q, owner_d;
  logic          wen_q, wen_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          m0_rvalid_q, m0_rvalid_d;
  logic [31:0]   m0_rdata_q, m0_rdata_d;
  logic          m0_err_q, m0_err_d;
  logic          m1_rvalid_q, m1_rvalid_d;
  logic [31:0]   m1_rdata_q, m1_rdata_d;
  logic          m1_err_q, m1_err_d;

  logic        any_valid;
  logic        winner;
  logic        done;
  logic        timed_out;
  logic        finish;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // On a tie the master that did not win last time gets the port; last_gnt
  // resets to m0 so m1 wins the first tie.
  assign any_valid = i_m0_valid | i_m1_valid;
  assign winner    = (i_m0_valid & i_m1_valid) ? ~last_gnt_q : i_m1_valid;

  assign o_m0_ready = (state_q == IDLE) & any_valid & ~winner;
  assign o_m1_ready = (state_q == IDLE) & any_valid &  winner;

  // A response seen in REQ only counts when it arrives with the accept.
  assign done = ((state_q == REQ) & i_s_ready & i_s_rvalid) |
                ((state_q == RESP) & i_s_rvalid);

  // A real response on the last allowed cycle beats the timeout.
  assign timed_out = (state_q != IDLE) & (counter_q == TO_LAST) & ~done;
  assign finish    = done | timed_out;

  assign resp_rdata = (done & ~wen_q) ? i_s_rdata : 32'd0;
  assign resp_err   = done ? i_s_err : 1'b1;

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    m0_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m0_err_d    = m0_err_q;
    m1_rvalid_d = 1'b0;
    m1_rdata_d  = m1_rdata_q;
    m1_err_d    = m1_err_q;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d    = REQ;
          counter_d  = '0;
          owner_d    = winner;
          last_gnt_d = winner;
          if (winner) begin
            wen_d   = i_m1_wen;
            addr_d  = i_m1_addr;
            wdata_d = i_m1_wdata;
            wmask_d = i_m1_wmask;
          end else begin
            // The IFU only reads; its write fields are forced inert.
            wen_d   = 1'b0;
            addr_d  = i_m0_addr;
            wdata_d = 32'd0;
            wmask_d = 4'd0;
          end
        end
      end
      REQ: begin
        counter_d = counter_q + CW'(1);
        if (finish) begin
          state_d = IDLE;
        end else if (i_s_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        counter_d = counter_q + CW'(1);
        if (finish) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Response is steered to the owner; the other master's data is untouched.
    if (finish) begin
      if (owner_q) begin
        m1_rvalid_d = 1'b1;
        m1_rdata_d  = resp_rdata;
        m1_err_d    = resp_err;
      end else begin
        m0_rvalid_d = 1'b1;
        m0_rdata_d  = resp_rdata;
        m0_err_d    = resp_err;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      last_gnt_q  <= 1'b0;
      owner_q     <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wmask_q     <= 4'd0;
      m0_rvalid_q <= 1'b0;
      m0_rdata_q  <= 32'd0;
      m0_err_q    <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m1_rdata_q  <= 32'd0;
      m1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      last_gnt_q  <= last_gnt_d;
      owner_q     <= owner_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      m0_rvalid_q <= m0_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m0_err_q    <= m0_err_d;
      m1_rvalid_q <= m1_rvalid_d;
      m1_rdata_q  <= m1_rdata_d;
      m1_err_q    <= m1_err_d;
    end
  end

  // Slave payload is gated by valid so the bus reads as zero when idle.
  assign o_s_valid = (state_q == REQ);
  assign o_s_wen   = o_s_valid & wen_q;
  assign o_s_addr  = o_s_valid ? addr_q  : 32'd0;
  assign o_s_wdata = o_s_valid ? wdata_q : 32'd0;
  assign o_s_wmask = o_s_valid ? wmask_q : 4'd0;

  assign o_m0_rvalid = m0_rvalid_q;
  assign o_m0_rdata  = m0_rdata_q;
  assign o_m0_err    = m0_err_q;
  assign o_m1_rvalid = m1_rvalid_q;
  assign o_m1_rdata  = m1_rdata_q;
  assign o_m1_err    = m1_err_q;

  assign o_busy  = (state_q != IDLE);
  assign o_owner = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter (TIMEOUT=8). A cycle table drives inputs at the
// falling edge and checks outputs 1 ns later; the timeout, reset-abandon and
// back-to-back tie cases are written out as sequences.
module tb_mem_bus_arbiter;

  localparam logic [31:0] A0   = 32'h8000_0000;
  localparam logic [31:0] A1   = 32'h8000_1004;
  localparam logic [31:0] WD   = 32'hDEAD_BEEF;
  localparam logic [3:0]  WM   = 4'b0011;
  localparam logic [31:0] R413 = 32'h0000_0413;
  localparam logic [31:0] RX   = 32'h1234_5678;
  localparam logic [31:0] RC   = 32'hCAFE_0001;
  localparam logic [31:0] RF   = 32'hFFFF_FFFF;
  localparam int          NV   = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_valid = 1'b0;
  logic        m0_ready, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_valid = 1'b0;
  logic        m1_wen = 1'b0;
  logic        m1_ready, m1_rvalid, m1_err;
  logic [31:0] m1_rdata;
  logic        s_valid, s_wen;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wmask;
  logic        s_ready = 1'b0;
  logic        s_rvalid = 1'b0;
  logic [31:0] s_rdata = 32'd0;
  logic        s_err = 1'b0;
  logic        busy, owner;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(8), .CW(16)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_m0_valid  (m0_valid),
    .i_m0_addr   (A0),
    .o_m0_ready  (m0_ready),
    .o_m0_rvalid (m0_rvalid),
    .o_m0_rdata  (m0_rdata),
    .o_m0_err    (m0_err),
    .i_m1_valid  (m1_valid),
    .i_m1_wen    (m1_wen),
    .i_m1_addr   (A1),
    .i_m1_wdata  (WD),
    .i_m1_wmask  (WM),
    .o_m1_ready  (m1_ready),
    .o_m1_rvalid (m1_rvalid),
    .o_m1_rdata  (m1_rdata),
    .o_m1_err    (m1_err),
    .o_s_valid   (s_valid),
    .o_s_wen     (s_wen),
    .o_s_addr    (s_addr),
    .o_s_wdata   (s_wdata),
    .o_s_wmask   (s_wmask),
    .i_s_ready   (s_ready),
    .i_s_rvalid  (s_rvalid),
    .i_s_rdata   (s_rdata),
    .i_s_err     (s_err),
    .o_busy      (busy),
    .o_owner     (owner)
  );

  typedef struct {
    logic        rst, m0v, m1v, m1wen, srdy, srv, serr;
    logic [31:0] srdata;
    logic        chk;
    logic        m0rdy, m1rdy, sv;
    logic [31:0] saddr;
    logic        swen;
    logic [31:0] swd;
    logic [3:0]  swm;
    logic        m0rv;
    logic [31:0] m0rd;
    logic        m0err;
    logic        m1rv;
    logic [31:0] m1rd;
    logic        m1err;
    logic        busy, owner;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v0, input logic v1, input logic w1,
                       input logic rdy, input logic rv, input logic er, input logic [31:0] rd);
    @(negedge clk);
    rst      = r;
    m0_valid = v0;
    m1_valid = v1;
    m1_wen   = w1;
    s_ready  = rdy;
    s_rvalid = rv;
    s_err    = er;
    s_rdata  = rd;
    #1;
  endtask

  initial begin
    int grants;
    logic [3:0] order;

    //        rst m0v m1v wen rdy rv er srdata chk  m0r m1r sv saddr swen swd swm  m0rv m0rd m0e  m1rv m1rd m1e  busy own
    vecs[0]  = '{1,0,0,0,0,0,0,0,     0,   0,0,0,0, 0,0,0,     0,0,0,    0,0,0,    0,0};
    vecs[1]  = '{1,0,0,0,0,0,0,0,     1,   0,0,0,0, 0,0,0,     0,0,0,    0,0,0,    0,0};
    vecs[2]  = '{0,1,0,0,0,0,0,0,     1,   1,0,0,0, 0,0,0,     0,0,0,    0,0,0,    0,0};
    vecs[3]  = '{0,0,0,0,0,0,0,0,     1,   0,0,1,A0,0,0,0,     0,0,0,    0,0,0,    1,0};
    vecs[4]  = '{0,0,0,0,1,0,0,0,     1,   0,0,1,A0,0,0,0,     0,0,0,    0,0,0,    1,0};
    vecs[5]  = '{0,0,0,0,0,0,0,0,     1,   0,0,0,0, 0,0,0,     0,0,0,    0,0,0,    1,0};
    vecs[6]  = '{0,0,0,0,0,1,0,R413,  1,   0,0,0,0, 0,0,0,     0,0,0,    0,0,0,    1,0};
    vecs[7]  = '{0,0,0,0,0,0,0,0,     1,   0,0,0,0, 0,0,0,     1,R413,0, 0,0,0,    0,0};
    vecs[8]  = '{0,0,0,0,0,0,0,0,     1,   0,0,0,0, 0,0,0,     0,R413,0, 0,0,0,    0,0};
    vecs[9]  = '{0,0,1,1,0,0,0,0,     1,   0,1,0,0, 0,0,0,     0,R413,0, 0,0,0,    0,0};
    vecs[10] = '{0,0,0,0,0,0,0,0,     1,   0,0,1,A1,1,WD,WM,   0,R413,0, 0,0,0,    1,1};
    vecs[11] = '{0,0,0,0,0,0,0,0,     1,   0,0,1,A1,1,WD,WM,   0,R413,0, 0,0,0,    1,1};
    vecs[12] = '{0,0,0,0,0,0,0,0,     1,   0,0,1,A1,1,WD,WM,   0,R413,0, 0,0,0,    1,1};
    vecs[13] = '{0,0,0,0,1,0,0,0,     1,   0,0,1,A1,1,WD,WM,   0,R413,0, 0,0,0,    1,1};
    vecs[14] = '{0,0,0,0,0,1,0,RF,    1,   0,0,0,0, 0,0,0,     0,R413,0, 0,0,0,    1,1};
    vecs[15] = '{0,0,0,0,0,0,0,0,     1,   0,0,0,0, 0,0,0,     0,R413,0, 1,0,0,    0,1};
    vecs[16] = '{0,0,1,0,0,0,0,0,     1,   0,1,0,0, 0,0,0,     0,R413,0, 0,0,0,    0,1};
    vecs[17] = '{0,0,0,0,1,1,0,RX,    1,   0,0,1,A1,0,WD,WM,   0,R413,0, 0,0,0,    1,1};
    vecs[18] = '{0,1,0,0,0,0,0,0,     1,   1,0,0,0, 0,0,0,     0,R413,0, 1,RX,0,   0,1};
    vecs[19] = '{0,0,0,0,1,0,0,0,     1,   0,0,1,A0,0,0,0,     0,R413,0, 0,RX,0,   1,0};
    vecs[20] = '{0,0,0,0,0,1,1,RC,    1,   0,0,0,0, 0,0,0,     0,R413,0, 0,RX,0,   1,0};
    vecs[21] = '{0,0,0,0,0,0,0,0,     1,   0,0,0,0, 0,0,0,     1,RC,1,   0,RX,0,   0,0};

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].m0v, vecs[i].m1v, vecs[i].m1wen,
            vecs[i].srdy, vecs[i].srv, vecs[i].serr, vecs[i].srdata);
      if (vecs[i].chk) begin
        chk($sformatf("r%0d_m0_ready", i),  {31'd0, m0_ready},  {31'd0, vecs[i].m0rdy});
        chk($sformatf("r%0d_m1_ready", i),  {31'd0, m1_ready},  {31'd0, vecs[i].m1rdy});
        chk($sformatf("r%0d_s_valid", i),   {31'd0, s_valid},   {31'd0, vecs[i].sv});
        chk($sformatf("r%0d_s_addr", i),    s_addr,             vecs[i].saddr);
        chk($sformatf("r%0d_s_wen", i),     {31'd0, s_wen},     {31'd0, vecs[i].swen});
        chk($sformatf("r%0d_s_wdata", i),   s_wdata,            vecs[i].swd);
        chk($sformatf("r%0d_s_wmask", i),   {28'd0, s_wmask},   {28'd0, vecs[i].swm});
        chk($sformatf("r%0d_m0_rvalid", i), {31'd0, m0_rvalid}, {31'd0, vecs[i].m0rv});
        chk($sformatf("r%0d_m0_rdata", i),  m0_rdata,           vecs[i].m0rd);
        chk($sformatf("r%0d_m0_err", i),    {31'd0, m0_err},    {31'd0, vecs[i].m0err});
        chk($sformatf("r%0d_m1_rvalid", i), {31'd0, m1_rvalid}, {31'd0, vecs[i].m1rv});
        chk($sformatf("r%0d_m1_rdata", i),  m1_rdata,           vecs[i].m1rd);
        chk($sformatf("r%0d_m1_err", i),    {31'd0, m1_err},    {31'd0, vecs[i].m1err});
        chk($sformatf("r%0d_busy", i),      {31'd0, busy},      {31'd0, vecs[i].busy});
        chk($sformatf("r%0d_owner", i),     {31'd0, owner},     {31'd0, vecs[i].owner});
      end
      if (m0_rvalid | m1_rvalid)
        $display("txn row %0d: m0_rvalid=%0b m0_rdata=%h m0_err=%0b m1_rvalid=%0b m1_rdata=%h m1_err=%0b",
                 i, m0_rvalid, m0_rdata, m0_err, m1_rvalid, m1_rdata, m1_err);
    end

    // Timeout: slave never answers; error completion 8 edges after the grant.
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    chk("to_grant_m0", {31'd0, m0_ready}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("to_wait%0d_rvalid", k), {31'd0, m0_rvalid}, 32'd0);
      chk($sformatf("to_wait%0d_s_valid", k), {31'd0, s_valid}, 32'd1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("to_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("to_err", {31'd0, m0_err}, 32'd1);
    chk("to_rdata", m0_rdata, 32'd0);
    chk("to_s_valid", {31'd0, s_valid}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);
    $display("txn timeout: m0_rvalid=%0b m0_err=%0b m0_rdata=%h", m0_rvalid, m0_err, m0_rdata);
    drive(0, 0, 0, 0, 0, 1, 0, 32'h55);
    chk("late_rv_m0_rvalid0", {31'd0, m0_rvalid}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("late_rv_m0_rvalid1", {31'd0, m0_rvalid}, 32'd0);
    chk("late_rv_m1_rvalid1", {31'd0, m1_rvalid}, 32'd0);
    chk("late_rv_busy", {31'd0, busy}, 32'd0);

    // Reset while in RESP abandons the transaction.
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    chk("rst_grant_m1", {31'd0, m1_ready}, 32'd1);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    chk("rst_req_s_valid", {31'd0, s_valid}, 32'd1);
    drive(1, 0, 0, 0, 0, 1, 0, RX);
    chk("rst_resp_busy", {31'd0, busy}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_after_busy", {31'd0, busy}, 32'd0);
    chk("rst_after_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_after_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    chk("rst_after_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);

    // Both masters valid continuously: grants alternate starting with m1.
    grants = 0;
    order  = 4'd0;
    for (int c = 0; c < 20 && grants < 4; c++) begin
      drive(0, 1, 1, 0, 1, 1, 0, 32'h0000_00AA);
      chk($sformatf("tie_c%0d_dual_ready", c), {31'd0, m0_ready & m1_ready}, 32'd0);
      chk($sformatf("tie_c%0d_dual_rvalid", c), {31'd0, m0_rvalid & m1_rvalid}, 32'd0);
      if (m0_ready | m1_ready) begin
        order[grants] = m1_ready;
        $display("txn tie grant %0d: m%0d", grants, m1_ready ? 1 : 0);
        grants++;
      end
    end
    chk("tie_grant_count", grants, 32'd4);
    chk("tie_order", {28'd0, order}, 32'h5);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
